// File: rtl/snake_body_streamer_pkg.sv
// Shared playfield geometry, direction encoding and helpers for the snake body streamer.

package snake_body_streamer_pkg;

    localparam int unsigned GAME_WIDTH  = 30;
    localparam int unsigned GAME_HEIGHT = 14;

    localparam logic [4:0] HEAD_X0 = 5'(GAME_WIDTH / 2);
    localparam logic [3:0] HEAD_Y0 = 4'(GAME_HEIGHT / 2);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_body_streamer_if.sv
// Segment stream from the body streamer to the renderer, one segment per clock.

interface snake_body_streamer_if;
    import snake_body_streamer_pkg::*;

    logic [4:0] snake_x;
    logic [3:0] snake_y;
    dir_t       snake_dir;
    logic       snake_first;
    logic       snake_last;
    logic       snake_valid;

    modport master (
        output snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
    );

    modport slave (
        input snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
    );

endinterface

// File: rtl/snake_body_streamer_tile_step.sv
// Combinational one-tile move with playfield bounds check.

module snake_body_streamer_tile_step
    import snake_body_streamer_pkg::*;
(
    input  logic [4:0] x,
    input  logic [3:0] y,
    input  dir_t       dir,
    output logic [4:0] next_x,
    output logic [3:0] next_y,
    output logic       out_of_field
);

    always_comb begin
        next_x = x;
        next_y = y;
        unique case (dir)
            DIR_UP:    next_y = y - 4'd1;
            DIR_DOWN:  next_y = y + 4'd1;
            DIR_LEFT:  next_x = x - 5'd1;
            DIR_RIGHT: next_x = x + 5'd1;
        endcase
        out_of_field = (next_x == 5'd0) || (next_x > 5'(GAME_WIDTH)) ||
                       (next_y == 4'd0) || (next_y > 4'(GAME_HEIGHT));
    end

endmodule

// File: rtl/snake_body_streamer.sv
// Snake body state (head, length, direction ring) with a head-to-tail segment walker
// that streams continuously to the renderer and flags wall/self collisions.

module snake_body_streamer
    import snake_body_streamer_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_LEN = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       game_rst_n,
    input  logic                       step,
    input  dir_t                       step_dir,
    input  logic                       grow,
    output logic [4:0]                 snake_head_x,
    output logic [3:0]                 snake_head_y,
    output logic [$clog2(MAX_LEN)-1:0] length,
    output logic                       full,
    output logic                       failure,
    snake_body_streamer_if.master      seg
);

    localparam int unsigned PTR_W = $clog2(MAX_LEN);
    localparam int unsigned LEN_W = PTR_W + 1;

    dir_t             ring_q [MAX_LEN];
    logic [4:0]       head_x_q, head_x_d, walk_x_q, walk_x_d, out_x_q, out_x_d;
    logic [3:0]       head_y_q, head_y_d, walk_y_q, walk_y_d, out_y_q, out_y_d;
    logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
    logic [LEN_W-1:0] len_q, len_d, k_q, k_d;
    logic             failure_q, failure_d;
    dir_t             out_dir_q, out_dir_d;
    logic             out_first_q, out_first_d, out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;

    logic [PTR_W-1:0] new_ptr, rd_idx;
    dir_t             rd_dir;
    logic [4:0]       new_x, walk_nx;
    logic [3:0]       new_y, walk_ny;
    logic             new_oob, unused_walk_oob;
    logic             do_step, len_full, walk_last, self_hit;

    assign do_step   = step && !failure_q;
    assign new_ptr   = head_ptr_q - PTR_W'(1);
    assign rd_idx    = head_ptr_q + k_q[PTR_W-1:0];
    assign rd_dir    = ring_q[rd_idx];
    assign len_full  = (len_q == LEN_W'(MAX_LEN));
    assign walk_last = (k_q == len_q - LEN_W'(1));
    // Compare the segment just emitted against the head it was walked from.
    assign self_hit  = out_valid_q && !out_first_q &&
                       (out_x_q == head_x_q) && (out_y_q == head_y_q);

    snake_body_streamer_tile_step u_head_step (
        .x            (head_x_q),
        .y            (head_y_q),
        .dir          (step_dir),
        .next_x       (new_x),
        .next_y       (new_y),
        .out_of_field (new_oob)
    );

    snake_body_streamer_tile_step u_walk_step (
        .x            (walk_x_q),
        .y            (walk_y_q),
        .dir          (rd_dir),
        .next_x       (walk_nx),
        .next_y       (walk_ny),
        .out_of_field (unused_walk_oob)
    );

    always_comb begin
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        head_ptr_d  = head_ptr_q;
        len_d       = len_q;
        failure_d   = failure_q || self_hit;
        k_d         = k_q;
        walk_x_d    = walk_x_q;
        walk_y_d    = walk_y_q;
        out_x_d     = walk_x_q;
        out_y_d     = walk_y_q;
        out_dir_d   = rd_dir;
        out_first_d = (k_q == '0);
        out_last_d  = walk_last;
        out_valid_d = 1'b1;

        if (do_step) begin
            head_x_d   = new_x;
            head_y_d   = new_y;
            head_ptr_d = new_ptr;
            if (grow && !len_full) begin
                len_d = len_q + LEN_W'(1);
            end
            failure_d = failure_d || new_oob;
            // Abort the pass: emit the new head now, walker resumes at the old head (k = 1).
            out_x_d     = new_x;
            out_y_d     = new_y;
            out_dir_d   = opposite(step_dir);
            out_first_d = 1'b1;
            out_last_d  = 1'b0;
            k_d         = LEN_W'(1);
            walk_x_d    = head_x_q;
            walk_y_d    = head_y_q;
        end else if (walk_last) begin
            k_d      = '0;
            walk_x_d = head_x_q;
            walk_y_d = head_y_q;
        end else begin
            k_d      = k_q + LEN_W'(1);
            walk_x_d = walk_nx;
            walk_y_d = walk_ny;
        end

        if (!game_rst_n) begin
            head_x_d    = HEAD_X0;
            head_y_d    = HEAD_Y0;
            head_ptr_d  = '0;
            len_d       = LEN_W'(INIT_LEN);
            failure_d   = 1'b0;
            k_d         = '0;
            walk_x_d    = HEAD_X0;
            walk_y_d    = HEAD_Y0;
            out_x_d     = '0;
            out_y_d     = '0;
            out_dir_d   = DIR_UP;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_x_q    <= HEAD_X0;
            head_y_q    <= HEAD_Y0;
            head_ptr_q  <= '0;
            len_q       <= LEN_W'(INIT_LEN);
            failure_q   <= 1'b0;
            k_q         <= '0;
            walk_x_q    <= HEAD_X0;
            walk_y_q    <= HEAD_Y0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_dir_q   <= DIR_UP;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            head_ptr_q  <= head_ptr_d;
            len_q       <= len_d;
            failure_q   <= failure_d;
            k_q         <= k_d;
            walk_x_q    <= walk_x_d;
            walk_y_q    <= walk_y_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_dir_q   <= out_dir_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) ring_q[i] <= DIR_LEFT;
        end else if (!game_rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) ring_q[i] <= DIR_LEFT;
        end else if (do_step) begin
            ring_q[new_ptr] <= opposite(step_dir);
        end
    end

    // length carries len mod MAX_LEN; full distinguishes MAX_LEN from zero.
    assign snake_head_x    = head_x_q;
    assign snake_head_y    = head_y_q;
    assign length          = len_q[PTR_W-1:0];
    assign full            = len_full;
    assign failure         = failure_q;
    assign seg.snake_x     = out_x_q;
    assign seg.snake_y     = out_y_q;
    assign seg.snake_dir   = out_dir_q;
    assign seg.snake_first = out_first_q;
    assign seg.snake_last  = out_last_q;
    assign seg.snake_valid = out_valid_q;

endmodule

// File: tb/tb_snake_body_streamer.sv
// Directed bench for snake_body_streamer: per-cycle vector table plus collision/full/reset sequences.

module tb_snake_body_streamer;
    import snake_body_streamer_pkg::*;

    localparam int unsigned MAX_LEN  = 64;
    localparam int unsigned INIT_LEN = 3;
    localparam int          NVEC     = 23;

    logic       clk = 1'b0;
    logic       rst_n, game_rst_n, step, grow;
    dir_t       step_dir;
    logic [4:0] head_x;
    logic [3:0] head_y;
    logic [5:0] length;
    logic       full, failure;

    snake_body_streamer_if seg_if ();

    snake_body_streamer #(
        .MAX_LEN  (MAX_LEN),
        .INIT_LEN (INIT_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_rst_n   (game_rst_n),
        .step         (step),
        .step_dir     (step_dir),
        .grow         (grow),
        .snake_head_x (head_x),
        .snake_head_y (head_y),
        .length       (length),
        .full         (full),
        .failure      (failure),
        .seg          (seg_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       st;
        dir_t       d;
        logic       gr;
        logic [4:0] hx;
        logic [3:0] hy;
        int         len;
        logic       fail;
        logic [4:0] x;
        logic [3:0] y;
        int         sd;
        logic       first;
        logic       last;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic st, input dir_t d, input logic gr,
                                input int hx, input int hy, input int len, input logic fail,
                                input int x, input int y, input int sd,
                                input logic first, input logic last);
        vec_t v;
        v.st = st; v.d = d; v.gr = gr;
        v.hx = 5'(hx); v.hy = 4'(hy); v.len = len; v.fail = fail;
        v.x = 5'(x); v.y = 4'(y); v.sd = sd; v.first = first; v.last = last;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input dir_t d, input logic g);
        step = 1'b1; step_dir = d; grow = g;
        tick();
        step = 1'b0; grow = 1'b0;
    endtask

    task automatic game_reset();
        game_rst_n = 1'b0;
        tick();
        game_rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;

        rst_n = 1'b0; game_rst_n = 1'b1; step = 1'b0; grow = 1'b0; step_dir = DIR_UP;
        repeat (3) tick();
        chk("reset valid", int'(seg_if.snake_valid), 0);
        chk("reset first", int'(seg_if.snake_first), 0);
        chk("reset last", int'(seg_if.snake_last), 0);
        chk("reset failure", int'(failure), 0);
        chk("reset head_x", int'(head_x), 15);
        chk("reset head_y", int'(head_y), 7);
        chk("reset length", int'(length), 3);
        chk("reset full", int'(full), 0);
        rst_n = 1'b1;

        //            st dir        gr  hx  hy len f   x   y  sd fst lst
        vecs[0]  = mk(0, DIR_UP,    0, 15, 7, 3, 0, 15, 7, 2, 1, 0);
        vecs[1]  = mk(0, DIR_UP,    0, 15, 7, 3, 0, 14, 7, 2, 0, 0);
        vecs[2]  = mk(0, DIR_UP,    0, 15, 7, 3, 0, 13, 7, 2, 0, 1);
        vecs[3]  = mk(0, DIR_UP,    0, 15, 7, 3, 0, 15, 7, 2, 1, 0);
        vecs[4]  = mk(0, DIR_UP,    0, 15, 7, 3, 0, 14, 7, 2, 0, 0);
        vecs[5]  = mk(0, DIR_UP,    0, 15, 7, 3, 0, 13, 7, 2, 0, 1);
        vecs[6]  = mk(1, DIR_RIGHT, 0, 16, 7, 3, 0, 16, 7, 2, 1, 0);
        vecs[7]  = mk(0, DIR_UP,    0, 16, 7, 3, 0, 15, 7, 2, 0, 0);
        vecs[8]  = mk(0, DIR_UP,    0, 16, 7, 3, 0, 14, 7, 2, 0, 1);
        vecs[9]  = mk(0, DIR_UP,    0, 16, 7, 3, 0, 16, 7, 2, 1, 0);
        vecs[10] = mk(1, DIR_UP,    1, 16, 6, 4, 0, 16, 6, 1, 1, 0);
        vecs[11] = mk(1, DIR_UP,    1, 16, 5, 5, 0, 16, 5, 1, 1, 0);
        vecs[12] = mk(0, DIR_UP,    0, 16, 5, 5, 0, 16, 6, 1, 0, 0);
        vecs[13] = mk(0, DIR_UP,    0, 16, 5, 5, 0, 16, 7, 2, 0, 0);
        vecs[14] = mk(0, DIR_UP,    0, 16, 5, 5, 0, 15, 7, 2, 0, 0);
        vecs[15] = mk(0, DIR_UP,    0, 16, 5, 5, 0, 14, 7, 2, 0, 1);
        vecs[16] = mk(0, DIR_UP,    0, 16, 5, 5, 0, 16, 5, 1, 1, 0);
        vecs[17] = mk(0, DIR_UP,    0, 16, 5, 5, 0, 16, 6, 1, 0, 0);
        // walker sits at k=2 here: step aborts the pass
        vecs[18] = mk(1, DIR_LEFT,  0, 15, 5, 5, 0, 15, 5, 3, 1, 0);
        vecs[19] = mk(0, DIR_UP,    0, 15, 5, 5, 0, 16, 5, 1, 0, 0);
        vecs[20] = mk(0, DIR_UP,    0, 15, 5, 5, 0, 16, 6, 1, 0, 0);
        vecs[21] = mk(0, DIR_UP,    0, 15, 5, 5, 0, 16, 7, 2, 0, 0);
        vecs[22] = mk(0, DIR_UP,    0, 15, 5, 5, 0, 15, 7, 2, 0, 1);

        for (int i = 0; i < NVEC; i++) begin
            step = vecs[i].st; step_dir = vecs[i].d; grow = vecs[i].gr;
            tick();
            step = 1'b0; grow = 1'b0;
            chk($sformatf("vec%0d head_x", i), int'(head_x), int'(vecs[i].hx));
            chk($sformatf("vec%0d head_y", i), int'(head_y), int'(vecs[i].hy));
            chk($sformatf("vec%0d length", i), int'(length), vecs[i].len);
            chk($sformatf("vec%0d failure", i), int'(failure), int'(vecs[i].fail));
            chk($sformatf("vec%0d seg_x", i), int'(seg_if.snake_x), int'(vecs[i].x));
            chk($sformatf("vec%0d seg_y", i), int'(seg_if.snake_y), int'(vecs[i].y));
            chk($sformatf("vec%0d seg_dir", i), int'(seg_if.snake_dir), vecs[i].sd);
            chk($sformatf("vec%0d first", i), int'(seg_if.snake_first), int'(vecs[i].first));
            chk($sformatf("vec%0d last", i), int'(seg_if.snake_last), int'(vecs[i].last));
            chk($sformatf("vec%0d valid", i), int'(seg_if.snake_valid), 1);
        end

        // Self collision: grow to 5 heading right, then up, left, down onto own body.
        game_reset();
        chk("grst valid", int'(seg_if.snake_valid), 0);
        do_step(DIR_RIGHT, 1'b1);
        do_step(DIR_RIGHT, 1'b1);
        do_step(DIR_UP, 1'b0);
        do_step(DIR_LEFT, 1'b0);
        do_step(DIR_DOWN, 1'b0);
        chk("self length", int'(length), 5);
        chk("self head_x", int'(head_x), 16);
        chk("self head_y", int'(head_y), 7);
        repeat (4) tick();
        chk("self tail last", int'(seg_if.snake_last), 1);
        chk("self tail x", int'(seg_if.snake_x), 16);
        chk("self failure pending", int'(failure), 0);
        tick();
        chk("self failure set", int'(failure), 1);

        // Game reset mid-pass while failed.
        repeat (2) tick();
        game_reset();
        chk("grst failure", int'(failure), 0);
        chk("grst valid2", int'(seg_if.snake_valid), 0);
        chk("grst first", int'(seg_if.snake_first), 0);
        chk("grst last", int'(seg_if.snake_last), 0);
        chk("grst head_x", int'(head_x), 15);
        chk("grst head_y", int'(head_y), 7);
        chk("grst length", int'(length), 3);
        tick();
        chk("grst seg0 first", int'(seg_if.snake_first), 1);
        chk("grst seg0 x", int'(seg_if.snake_x), 15);

        // Wall: x=30 is the last playfield column, x=31 is border.
        for (int i = 0; i < 15; i++) do_step(DIR_RIGHT, 1'b0);
        chk("wall edge head_x", int'(head_x), 30);
        chk("wall edge failure", int'(failure), 0);
        do_step(DIR_RIGHT, 1'b0);
        chk("wall head_x", int'(head_x), 31);
        chk("wall failure", int'(failure), 1);
        do_step(DIR_UP, 1'b0);
        chk("frozen head_x", int'(head_x), 31);
        chk("frozen head_y", int'(head_y), 7);
        chk("frozen first", int'(seg_if.snake_first), 0);
        chk("frozen seg x", int'(seg_if.snake_x), 30);
        chk("frozen failure", int'(failure), 1);

        // Grow to MAX_LEN along the border loop, then two more grow steps.
        game_reset();
        for (int i = 0; i < 15; i++) do_step(DIR_RIGHT, 1'b1);
        for (int i = 0; i < 7; i++)  do_step(DIR_DOWN, 1'b1);
        for (int i = 0; i < 29; i++) do_step(DIR_LEFT, 1'b1);
        chk("grow54 length", int'(length), 54);
        chk("grow54 full", int'(full), 0);
        for (int i = 0; i < 10; i++) do_step(DIR_UP, 1'b1);
        chk("grow64 full", int'(full), 1);
        chk("grow64 length wraps", int'(length), 0);
        do_step(DIR_UP, 1'b1);
        do_step(DIR_UP, 1'b1);
        chk("full held", int'(full), 1);
        chk("full held length", int'(length), 0);
        chk("full head_y", int'(head_y), 2);
        chk("full seg0 first", int'(seg_if.snake_first), 1);
        k = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            k++;
            if (seg_if.snake_last) seen = 1;
        end
        chk("full pass last seen", int'(seen), 1);
        chk("full pass last k", k, 63);
        chk("full tail x", int'(seg_if.snake_x), 15);
        chk("full tail y", int'(seg_if.snake_y), 7);
        repeat (2) tick();
        chk("full no failure", int'(failure), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
